// File: rtl/ysyx_22041071_dmem_resp_if.sv
// Request/response bus between an initiator and the ysyx_22041071_dmem_resp data memory.
// The master drives requests and accepts responses; the slave is the memory.
interface ysyx_22041071_dmem_resp_if;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        req_wen;
    logic [63:0] req_wdata;
    logic [63:0] req_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/ysyx_22041071_dmem_resp.sv
// Single-outstanding 64-bit data memory with fixed access latency and a held response.
// Define YSYX_22041071_DMEM_ERR_EN to flag out-of-range addresses instead of aliasing them.
module ysyx_22041071_dmem_resp #(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned LATENCY    = 1,
    parameter logic [63:0] BASE_ADDR  = 64'h8000_0000
) (
    input logic                       clk,
    input logic                       reset,
    ysyx_22041071_dmem_resp_if.slave  bus
);

    localparam int unsigned Words   = 1 << DEPTH_LOG2;
    localparam logic [3:0]  CntInit = 4'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] addr_q, addr_d;
    logic        wen_q, wen_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] wmask_q, wmask_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [63:0] mem_q [Words];

    logic [63:0]           off;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  range_err;
    logic                  mem_we;
    logic [63:0]           rd_word;
    logic                  unused_bits;

    assign off     = addr_q - BASE_ADDR;
    assign idx     = off[DEPTH_LOG2+2:3];
    assign rd_word = mem_q[idx];

`ifdef YSYX_22041071_DMEM_ERR_EN
    assign range_err   = (addr_q < BASE_ADDR) | (|off[63:DEPTH_LOG2+3]);
    assign unused_bits = ^off[2:0];
`else
    assign range_err   = 1'b0;
    assign unused_bits = ^{off[63:DEPTH_LOG2+3], off[2:0], err_q};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    wen_d   = bus.req_wen;
                    wdata_d = bus.req_wdata;
                    wmask_d = bus.req_wmask;
                    cnt_d   = CntInit;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = StResp;
                    err_d   = range_err;
                    if (range_err || wen_q) begin
                        rdata_d = 64'h0;
                        mem_we  = wen_q & ~range_err;
                    end else begin
                        rdata_d = rd_word;
                    end
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                    rdata_d = 64'h0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            addr_q  <= 64'h0;
            wen_q   <= 1'b0;
            wdata_q <= 64'h0;
            wmask_q <= 64'h0;
            rdata_q <= 64'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array is never reset; a store still pending when reset hits is dropped.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem_q[idx] <= (rd_word & ~wmask_q) | (wdata_q & wmask_q);
        end
    end

    assign bus.req_ready = (state_q == StIdle) & ~reset;
    assign bus.rsp_valid = (state_q == StResp) & ~reset;
    assign bus.rsp_rdata = reset ? 64'h0 : rdata_q;
`ifdef YSYX_22041071_DMEM_ERR_EN
    assign bus.rsp_err   = err_q & ~reset;
`else
    assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_22041071_dmem_resp.sv
// Directed bench for ysyx_22041071_dmem_resp: one LATENCY=1 instance and one LATENCY=3 instance.
module tb_ysyx_22041071_dmem_resp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic reset3;

    ysyx_22041071_dmem_resp_if bus1 ();
    ysyx_22041071_dmem_resp_if bus3 ();

    ysyx_22041071_dmem_resp #(
        .DEPTH_LOG2 (12),
        .LATENCY    (1),
        .BASE_ADDR  (64'h8000_0000)
    ) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    ysyx_22041071_dmem_resp #(
        .DEPTH_LOG2 (12),
        .LATENCY    (3),
        .BASE_ADDR  (64'h8000_0000)
    ) u_dut3 (
        .clk   (clk),
        .reset (reset3),
        .bus   (bus3.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transaction; cyc counts cycles from the accept cycle to first rsp_valid.
    task automatic txn(input bit sel, input logic [63:0] addr, input logic wen,
                       input logic [63:0] wd, input logic [63:0] wm,
                       output logic [63:0] rd, output logic er, output int cyc);
        if (sel) begin
            bus3.req_valid = 1'b1; bus3.req_addr = addr; bus3.req_wen = wen;
            bus3.req_wdata = wd;   bus3.req_wmask = wm;
        end else begin
            bus1.req_valid = 1'b1; bus1.req_addr = addr; bus1.req_wen = wen;
            bus1.req_wdata = wd;   bus1.req_wmask = wm;
        end
        #1;
        check("accept_ready", {63'h0, sel ? bus3.req_ready : bus1.req_ready}, 64'h1);
        tick();
        bus1.req_valid = 1'b0;
        bus3.req_valid = 1'b0;
        cyc = 1;
        while (!(sel ? bus3.rsp_valid : bus1.rsp_valid) && cyc < 20) begin
            tick();
            cyc++;
        end
        rd = sel ? bus3.rsp_rdata : bus1.rsp_rdata;
        er = sel ? bus3.rsp_err : bus1.rsp_err;
        if (sel) bus3.rsp_ready = 1'b1; else bus1.rsp_ready = 1'b1;
        tick();
        bus1.rsp_ready = 1'b0;
        bus3.rsp_ready = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] rd;
        logic        er;
        int          cyc;
        int          acc[$];

        reset = 1'b1;
        reset3 = 1'b1;
        bus1.req_valid = 1'b0; bus1.req_addr = '0; bus1.req_wen = 1'b0;
        bus1.req_wdata = '0;   bus1.req_wmask = '0; bus1.rsp_ready = 1'b0;
        bus3.req_valid = 1'b0; bus3.req_addr = '0; bus3.req_wen = 1'b0;
        bus3.req_wdata = '0;   bus3.req_wmask = '0; bus3.rsp_ready = 1'b0;
        tick();
        tick();
        check("rst_req_ready", {63'h0, bus1.req_ready}, 64'h0);
        check("rst_rsp_valid", {63'h0, bus1.rsp_valid}, 64'h0);
        check("rst_rsp_rdata", bus1.rsp_rdata, 64'h0);
        check("rst_rsp_err",   {63'h0, bus1.rsp_err}, 64'h0);
        reset = 1'b0;
        reset3 = 1'b0;
        tick();
        check("idle_req_ready", {63'h0, bus1.req_ready}, 64'h1);

        // Full-word store then load
        txn(0, 64'h8000_0010, 1'b1, 64'h1122_3344_5566_7788, '1, rd, er, cyc);
        check("st_latency", 64'(cyc), 64'd2);
        check("st_rdata", rd, 64'h0);
        check("st_err", {63'h0, er}, 64'h0);
        txn(0, 64'h8000_0010, 1'b0, '0, '0, rd, er, cyc);
        check("ld_latency", 64'(cyc), 64'd2);
        check("ld_rdata", rd, 64'h1122_3344_5566_7788);

        // Byte-lane store merges into existing word
        txn(0, 64'h8000_0011, 1'b1, 64'h0000_0000_0000_AA00, 64'h0000_0000_0000_FF00,
            rd, er, cyc);
        txn(0, 64'h8000_0010, 1'b0, '0, '0, rd, er, cyc);
        check("byte_merge", rd, 64'h1122_3344_5566_AA88);

        txn(0, 64'h8000_0018, 1'b1, 64'hCAFE_F00D_1234_5678, '1, rd, er, cyc);
        txn(0, 64'h8000_0000, 1'b1, 64'h0123_4567_89AB_CDEF, '1, rd, er, cyc);

        // Zero-mask store still responds but writes nothing
        txn(0, 64'h8000_0010, 1'b1, '1, '0, rd, er, cyc);
        check("zmask_latency", 64'(cyc), 64'd2);
        check("zmask_err", {63'h0, er}, 64'h0);
        txn(0, 64'h8000_0010, 1'b0, '0, '0, rd, er, cyc);
        check("zmask_nochange", rd, 64'h1122_3344_5566_AA88);

        // Response stall with a competing store held on the request side
        bus1.req_valid = 1'b1; bus1.req_addr = 64'h8000_0010; bus1.req_wen = 1'b0;
        tick();
        bus1.req_addr = 64'h8000_0018; bus1.req_wen = 1'b1;
        bus1.req_wdata = 64'h0; bus1.req_wmask = '1;
        tick();
        check("stall_first_valid", {63'h0, bus1.rsp_valid}, 64'h1);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", {63'h0, bus1.rsp_valid}, 64'h1);
            check("stall_rdata", bus1.rsp_rdata, 64'h1122_3344_5566_AA88);
            check("stall_err", {63'h0, bus1.rsp_err}, 64'h0);
            check("stall_req_ready", {63'h0, bus1.req_ready}, 64'h0);
            tick();
        end
        bus1.req_valid = 1'b0;
        bus1.rsp_ready = 1'b1;
        tick();
        bus1.rsp_ready = 1'b0;
        check("release_valid", {63'h0, bus1.rsp_valid}, 64'h0);
        check("release_ready", {63'h0, bus1.req_ready}, 64'h1);
        txn(0, 64'h8000_0018, 1'b0, '0, '0, rd, er, cyc);
        check("stall_store_ignored", rd, 64'hCAFE_F00D_1234_5678);

`ifdef YSYX_22041071_DMEM_ERR_EN
        txn(0, 64'h7FFF_FFF8, 1'b0, '0, '0, rd, er, cyc);
        check("err_low_latency", 64'(cyc), 64'd2);
        check("err_low_err", {63'h0, er}, 64'h1);
        check("err_low_rdata", rd, 64'h0);
        txn(0, 64'h8000_8000, 1'b1, 64'h5555_5555_5555_5555, '1, rd, er, cyc);
        check("err_high_err", {63'h0, er}, 64'h1);
        check("err_high_rdata", rd, 64'h0);
        txn(0, 64'h8000_0000, 1'b0, '0, '0, rd, er, cyc);
        check("err_mem_unchanged", rd, 64'h0123_4567_89AB_CDEF);
`else
        txn(0, 64'h8000_8010, 1'b0, '0, '0, rd, er, cyc);
        check("alias_rdata", rd, 64'h1122_3344_5566_AA88);
        check("alias_err", {63'h0, er}, 64'h0);
        txn(0, 64'h8000_8000, 1'b1, 64'h5555_5555_5555_5555, '1, rd, er, cyc);
        txn(0, 64'h8000_0000, 1'b0, '0, '0, rd, er, cyc);
        check("alias_store", rd, 64'h5555_5555_5555_5555);
`endif

        // LATENCY=3: latency, then reset while a store waits
        txn(1, 64'h8000_0020, 1'b1, 64'hA5A5_0000_FFFF_1234, '1, rd, er, cyc);
        check("lat3_latency", 64'(cyc), 64'd4);
        bus3.req_valid = 1'b1; bus3.req_addr = 64'h8000_0020; bus3.req_wen = 1'b1;
        bus3.req_wdata = 64'hDEAD_BEEF_DEAD_BEEF; bus3.req_wmask = '1;
        tick();
        bus3.req_valid = 1'b0;
        reset3 = 1'b1;
        tick();
        reset3 = 1'b0;
        #1;
        check("rst_wait_valid", {63'h0, bus3.rsp_valid}, 64'h0);
        tick();
        tick();
        tick();
        check("rst_wait_valid_later", {63'h0, bus3.rsp_valid}, 64'h0);
        txn(1, 64'h8000_0020, 1'b0, '0, '0, rd, er, cyc);
        check("rst_store_dropped", rd, 64'hA5A5_0000_FFFF_1234);

        // Back-to-back loads with rsp_ready held high
        bus3.req_valid = 1'b1; bus3.req_addr = 64'h8000_0020; bus3.req_wen = 1'b0;
        bus3.rsp_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (bus3.req_ready) acc.push_back(c);
            if (bus3.rsp_valid) check("b2b_rdata", bus3.rsp_rdata, 64'hA5A5_0000_FFFF_1234);
            tick();
        end
        bus3.req_valid = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        bus3.rsp_ready = 1'b0;
        check("b2b_count", {63'h0, acc.size() >= 3}, 64'h1);
        if (acc.size() >= 3) begin
            check("b2b_first", 64'(acc[0]), 64'd0);
            check("b2b_gap1", 64'(acc[1] - acc[0]), 64'd5);
            check("b2b_gap2", 64'(acc[2] - acc[1]), 64'd5);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ysyx_22041071_dmem_resp.md
YSYX_22041071_DMEM_RESP -- requirements
Module: ysyx_22041071_dmem_resp

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 12, giving log2 of the number of 64-bit words in the array.
REQ-002 SHALL have parameter LATENCY, default 1, legal range 1..15, giving WAIT-state cycles per access.
REQ-003 SHALL have parameter BASE_ADDR, default 64'h8000_0000, the byte address of word 0.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-006 SHALL have port req_valid, input, 1 bit: the initiator presents a request.
REQ-007 SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-008 SHALL have port req_addr, input, 64 bits: byte address.
REQ-009 SHALL have port req_wen, input, 1 bit: 1 means store, 0 means load.
REQ-010 SHALL have port req_wdata, input, 64 bits: store data, already lane-aligned.
REQ-011 SHALL have port req_wmask, input, 64 bits: bit-granular write mask.
REQ-012 SHALL have port rsp_valid, output, 1 bit: a response is available.
REQ-013 SHALL have port rsp_ready, input, 1 bit: the initiator accepts the response.
REQ-014 SHALL have port rsp_rdata, output, 64 bits: the full 64-bit word read.
REQ-015 SHALL have port rsp_err, output, 1 bit: access error.

Function
REQ-016 SHALL compute the word index as (req_addr - BASE_ADDR) >> 3 and use its low DEPTH_LOG2 bits as the array index.
REQ-017 SHALL implement the FSM states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE with reset low.
REQ-018 SHALL, on accept (req_valid & req_ready in cycle N), latch addr, wen, wdata and wmask, load cnt = LATENCY-1, and enter WAIT.
REQ-019 SHALL, in WAIT, decrement cnt when cnt != 0; when cnt == 0 it SHALL perform the access at that edge and enter RESP.
REQ-020 SHALL raise rsp_valid first in cycle N+LATENCY+1.
REQ-021 SHALL, on a store, write mem[idx] = (mem[idx] & ~wmask) | (wdata & wmask), and rsp_rdata SHALL be 64'h0.
REQ-022 SHALL, on a load, set rsp_rdata = mem[idx], with no lane extraction or sign extension.
REQ-023 SHALL, in RESP, hold rsp_valid, rsp_rdata and rsp_err stable until rsp_valid & rsp_ready.
REQ-024 SHALL return to IDLE after the response handshake; the next accept is possible no earlier than the following cycle.
REQ-025 SHALL ignore req_* inputs outside IDLE; there is exactly one outstanding transaction.
REQ-026 SHALL treat a store with req_wmask = 0 as a no-op write that still produces a response.

Reset
REQ-027 SHALL, while reset is high, force state IDLE, cnt 0, rsp_valid 0, rsp_rdata 64'h0, rsp_err 0 and req_ready 0.
REQ-028 SHALL, on reset mid-transaction (WAIT or RESP), drop the transaction: an unperformed store is not written and a pending response is discarded.
REQ-029 SHALL NOT reset the array contents.

Configuration
REQ-030 SHALL use the macro YSYX_22041071_DMEM_ERR_EN to control range checking.
REQ-031 SHALL, when YSYX_22041071_DMEM_ERR_EN is defined, flag req_addr < BASE_ADDR, or a word index >= 2^DEPTH_LOG2, as an error: no array write, rsp_rdata 0, rsp_err 1, same latency as a normal access.
REQ-032 SHALL, when YSYX_22041071_DMEM_ERR_EN is undefined, tie rsp_err to 0 and alias addresses modulo 2^DEPTH_LOG2 words.

Verification (LATENCY=1, DEPTH_LOG2=12 unless stated)
REQ-033 SHALL cover: store 0x8000_0010, wdata 0x1122334455667788, wmask all-ones, accepted in cycle N -> rsp_valid in N+2, rsp_rdata 0; a following load returns 0x1122334455667788.
REQ-034 SHALL cover: byte store 0x8000_0011, wmask 0x0000_0000_0000_FF00, wdata 0x0000_0000_0000_AA00 over the word above -> a subsequent load returns 0x112233445566AA88.
REQ-035 SHALL cover: rsp_ready held low 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stable, req_ready 0, a concurrent req_valid is not accepted; release -> IDLE next cycle.
REQ-036 SHALL cover: with the macro, load 0x7FFF_FFF8 -> rsp_err 1, rsp_rdata 0; store 0x8000_8000 -> rsp_err 1 and memory unchanged. Without the macro, 0x8000_8010 aliases 0x8000_0010.
REQ-037 SHALL cover: reset pulsed while a store is in WAIT with LATENCY=3 -> rsp_valid 0 the cycle after reset; a later load returns the prior value.
REQ-038 SHALL cover: LATENCY=3, accept in cycle N -> rsp_valid first high in cycle N+4; back-to-back loads achieve one transaction per 5 cycles when rsp_ready is held at 1.
